hex_scan_ctrl: RTL and testbench

//  Upstream feeder for the dual-digit hex 7-segment decoder.

---
 rtl/hex_scan_ctrl.sv | 91 +++++++++
 tb/tb_hex_scan_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: valid/ready byte holder and digit-scan generator for a dual-digit hex 7-segment decoder.
// Optional build macro HEX_SCAN_FREEZE_EN adds a freeze input that blocks new data while the scan keeps running.
module hex_scan_ctrl #(
    parameter int SCAN_DIV   = 50000,
    parameter int HOLD_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef HEX_SCAN_FREEZE_EN
    input  logic       freeze,
`endif
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] hex,
    output logic       digit_sel,
    output logic       frame_tick
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int HOLD_W = $clog2(HOLD_SCANS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SCANS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              div_wrap;
    logic              accept;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign accept   = in_valid && in_ready;

`ifdef HEX_SCAN_FREEZE_EN
    assign in_ready = (state == IDLE) && !freeze;
`else
    assign in_ready = (state == IDLE);
`endif

    // Free-running prescaler; frame_tick marks the cycle digit_sel returns to the low-nibble phase.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            digit_sel  <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= div_wrap && !digit_sel;
            if (div_wrap) begin
                div_cnt   <= '0;
                digit_sel <= ~digit_sel;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // A tick coinciding with the transfer falls in IDLE, so it is never counted toward the hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            hex      <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hex      <= in_data;
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (frame_tick) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_LAST) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench for hex_scan_ctrl: a cycle-indexed arithmetic model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_hex_scan_ctrl;

    localparam int S     = 4;
    localparam int H     = 2;
    localparam int FRAME = 2 * S;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       freeze_s = 1'b0;
    logic       in_ready;
    logic [7:0] hex;
    logic       digit_sel;
    logic       frame_tick;

    typedef struct {
        int         cyc;
        logic       ready;
        logic [7:0] hex;
        logic       dsel;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    int   ready_from = 0;
    logic [7:0] hex_m = 8'h00;

    hex_scan_ctrl #(.SCAN_DIV(S), .HOLD_SCANS(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef HEX_SCAN_FREEZE_EN
        .freeze     (freeze_s),
`endif
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .hex        (hex),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model, in cycles since reset release: digit phase = floor(k/S), frame ticks at nonzero multiples of 2S.
    function automatic logic m_dsel(input int c);
        return ((c / S) % 2) == 0;
    endfunction

    function automatic logic m_tick(input int c);
        return (c > 0) && (c % FRAME == 0);
    endfunction

    function automatic logic frozen();
`ifdef HEX_SCAN_FREEZE_EN
        return freeze_s;
`else
        return 1'b0;
`endif
    endfunction

    // First cycle ready again after a transfer in cycle c0: the H-th tick strictly after c0, plus one.
    function automatic int hold_end(input int c0);
        int t1;
        t1 = (c0 / FRAME + 1) * FRAME;
        return t1 + (H - 1) * FRAME + 1;
    endfunction

    task automatic drive_cycle(input logic v, input logic [7:0] d);
        exp_t e;
        logic rdy;
        in_valid = v;
        in_data  = d;
        rdy      = (k >= ready_from) && !frozen();
        e.cyc    = k;
        e.ready  = rdy;
        e.hex    = hex_m;
        e.dsel   = m_dsel(k);
        e.tick   = m_tick(k);
        exp_q.push_back(e);
        if (v && rdy) begin
            hex_m      = d;
            ready_from = hold_end(k);
        end
        @(posedge clk);
        #1;
        k++;
    endtask

    // Called just after a posedge; asserts reset mid-cycle and releases it just after a later posedge.
    task automatic do_reset(input int offs);
        #(offs);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_hex", 32'(hex), 32'h00);
        check("rst_digit_sel", 32'(digit_sel), 32'h1);
        check("rst_frame_tick", 32'(frame_tick), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        k          = 0;
        ready_from = 0;
        hex_m      = 8'h00;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("in_ready[c%0d]", e.cyc), 32'(in_ready), 32'(e.ready));
            check($sformatf("hex[c%0d]", e.cyc), 32'(hex), 32'(e.hex));
            check($sformatf("digit_sel[c%0d]", e.cyc), 32'(digit_sel), 32'(e.dsel));
            check($sformatf("frame_tick[c%0d]", e.cyc), 32'(frame_tick), 32'(e.tick));
        end
    end

    initial begin
        bit issued;
        int rst_at;

        // Power-on reset and release.
        #1 rst_n = 1'b0;
        #1;
        check("por_hex", 32'(hex), 32'h00);
        check("por_digit_sel", 32'(digit_sel), 32'h1);
        check("por_frame_tick", 32'(frame_tick), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle scan, then A5, then 3C held valid throughout the A5 hold.
        repeat (3) drive_cycle(1'b0, 8'h00);
        drive_cycle(1'b1, 8'hA5);
        for (int i = 0; i < 40 && hex_m != 8'h3C; i++) drive_cycle(1'b1, 8'h3C);
        repeat (4) drive_cycle(1'b0, 8'hFF);

        // Transfer exactly on a frame_tick cycle.
        issued = 1'b0;
        for (int i = 0; i < 60 && !issued; i++) begin
            if (m_tick(k) && k >= ready_from) begin
                drive_cycle(1'b1, 8'h5A);
                issued = 1'b1;
            end else begin
                drive_cycle(1'b0, 8'h00);
            end
        end
        check("tick_transfer_issued", 32'(issued), 32'h1);
        repeat (20) drive_cycle(1'b0, 8'h00);

        // Reset mid-HOLD while digit_sel=0 and hex=A5.
        do_reset(2);
        drive_cycle(1'b0, 8'h00);
        drive_cycle(1'b1, 8'hA5);
        repeat (3) drive_cycle(1'b0, 8'h00);
        do_reset(3);
        repeat (3) drive_cycle(1'b0, 8'h00);

`ifdef HEX_SCAN_FREEZE_EN
        // Freeze across the hold end with 77 pending; taken the cycle freeze drops.
        drive_cycle(1'b1, 8'hA5);
        freeze_s = 1'b1;
        repeat (25) drive_cycle(1'b1, 8'h77);
        freeze_s = 1'b0;
        repeat (3) drive_cycle(1'b1, 8'h77);
        repeat (20) drive_cycle(1'b0, 8'h00);
`endif

        // Randomized traffic with one async reset at a random point.
        rst_at = $urandom_range(100, 300);
        for (int i = 0; i < 500; i++) begin
`ifdef HEX_SCAN_FREEZE_EN
            freeze_s = ($urandom_range(0, 7) == 0);
`endif
            drive_cycle(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
            if (i == rst_at) begin
                do_reset($urandom_range(1, 8));
            end
        end

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
